dev_uart_tx: RTL and testbench
==============================

Name: dev_uart_tx

Overview:
- Device-side UART transmitter: the far end of the link, driving the line that the host UART receiver samples.
- Internal sync FIFO accepts bytes from device logic.
- Serialises 8N(1..15) frames, with optional parity, at an NCO-derived baud.
- Honours the host's RTS, wired to this block's cts, for hardware flow control.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries (default 16)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
baud_nco  input  32  NCO phase increment per clk; bit period = 2^32/baud_nco clks
stop_bit  input  4  stop-bit periods per frame; 0 treated as 1
flow_control  input  1  1 = gate frame start on cts
cts  input  1  clear-to-send, active-low (0 = send permitted), asynchronous
txd  output  1  serial line, idle high
wr_en  input  1  push wr_data into FIFO
wr_data  input  8  byte to send
fifo_full  output  1  FIFO holds 2**FIFO_AW bytes
fifo_level  output  FIFO_AW+1  current FIFO occupancy
overflow  output  1  one-cycle pulse when wr_en is dropped because the FIFO is full
tx_busy  output  1  high from START entry until the last stop period ends

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values while reset_n=0 at a clk edge:
  - txd=1, tx_busy=0, fifo_full=0, fifo_level=0, overflow=0
  - FIFO pointers 0, NCO accumulator 0, FSM=IDLE, cts synchroniser=2'b11
- Reset mid-frame aborts the frame immediately: txd returns to 1 the next cycle.
- cts passes through a 2-flop synchroniser: cts_s.
- FIFO write/full rules:
  - Write accepted when wr_en && !fifo_full.
  - Full is evaluated before the same-cycle pop. A write arriving while full is dropped even if a pop occurs that cycle, and overflow=1 for that cycle.
  - fifo_level updates the cycle after any push/pop; push and pop together leave the level unchanged.
- NCO:
  - acc <= acc + baud_nco (32-bit wrap); baud_tick = carry-out of that add.
  - acc is cleared on the IDLE->START transition, so the start bit spans a full period.
  - acc is held at 0 in IDLE.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
  - IDLE: txd=1. Pop when FIFO non-empty && (!flow_control || cts_s==0). The popped byte is loaded into an 8-bit shift register, next state START.
  - START: txd=0. On baud_tick: bit_cnt=0, go to DATA.
  - DATA: txd=shift[0], LSB first. On baud_tick: shift right, bit_cnt++. After bit 7 go to PARITY (if enabled) else STOP; stop_cnt=0.
  - PARITY: txd=parity bit. On baud_tick go to STOP.
  - STOP: txd=1. On baud_tick stop_cnt++. When stop_cnt reaches max(stop_bit,1): tx_busy drops and the FSM goes to IDLE. If the FIFO is non-empty and the cts condition holds that same cycle, it pops directly and the next cycle is START (back-to-back frames, no idle gap).
- Latency: wr_en at cycle N into an empty FIFO with the FSM idle and flow permitted → pop at N+1 → txd=0 and tx_busy=1 at N+2.
- cts deassertion mid-frame never aborts: the current frame completes, and the next one is held in IDLE.
- stop_bit, baud_nco and the flow_control input are sampled continuously; changes apply from the next tick.
- Changing stop_bit mid-STOP compares against the new value; if it is already exceeded, exit on the next tick.
- baud_nco=0: no ticks, the FSM stalls in its current state. Only reset or a non-zero value recovers.

Optional Feature:
- Macro: DEV_UART_TX_PARITY_EN.
- Defined:
  - Adds inputs parity_en (1) and parity_odd (1), sampled at pop and held for the frame.
  - With parity_en=1, the PARITY state emits ^data (even parity) or ~^data (odd parity) after bit 7.
  - With parity_en=0, PARITY is skipped.
- Undefined: the ports and the PARITY state are absent; frames are always 8N.

Decomposition:
- define.v carries:
  - FSM state encodings (DUTX_IDLE/START/DATA/PARITY/STOP, 3-bit)
  - the UART idle line level constant
  - the default FIFO_AW
- timescale.v is included as elsewhere.
- One sub-module: dev_uart_tx_fifo. It is a sync FIFO with wr_en/wr_data/rd_en/rd_data (first-word fall-through), full/empty/level, and the same clk/reset_n.

Test Plan:
- Baseline frame: baud_nco=9895604 (115200 at 50 MHz), stop_bit=1, flow_control=0, write 0xA5 → txd shows 0,1,0,1,0,0,1,0,1,1, each bit 434±1 clks; tx_busy drops after the stop bit.
- Flow control: flow_control=1, cts=1, write 3 bytes → txd stays 1 and fifo_level=3. Drop cts to 0 → frames 0x01,0x02,0x03 go out back-to-back with no idle gap. Raise cts mid-frame 2 → frame 2 completes, frame 3 is held.
- FIFO full: write 17 bytes with cts=1 → fifo_full=1 after 16, overflow pulses once on the 17th, fifo_level=16. Release cts → exactly 16 bytes are sent.
- Stop bits: stop_bit=0 yields 1 stop period; stop_bit=2 yields 868±2 clks high between back-to-back frames.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 → next cycle txd=1, tx_busy=0, fifo_level=0. After release, a new 0x5A frame is correct.
- Parity (DEV_UART_TX_PARITY_EN): parity_en=1, parity_odd=0, byte 0x07 → parity bit 1. parity_odd=1 → parity bit 0. Frame length 11 bit periods.

Source files
------------

// File: rtl/dev_uart_tx_pkg.sv
// dev_uart_tx shared definitions: FSM state encodings, idle line level,
// default FIFO size and the stop-period limit helper.
package dev_uart_tx_pkg;

    typedef enum logic [2:0] {
        DUTX_IDLE   = 3'd0,
        DUTX_START  = 3'd1,
        DUTX_DATA   = 3'd2,
        DUTX_PARITY = 3'd3,
        DUTX_STOP   = 3'd4
    } dutx_state_e;

    localparam logic DUTX_LINE_IDLE = 1'b1;
    localparam int   DUTX_FIFO_AW   = 4;

    // A stop_bit setting of zero still sends one stop period.
    function automatic logic [4:0] dutx_stop_lim(input logic [3:0] sb);
        return (sb == 4'd0) ? 5'd1 : {1'b0, sb};
    endfunction

endpackage

// File: rtl/dev_uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO for dev_uart_tx.
// Full is judged on the registered level, before any same-cycle pop.
module dev_uart_tx_fifo
    import dev_uart_tx_pkg::*;
#(
    parameter int AW = DUTX_FIFO_AW
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [7:0]    mem_q [2**AW];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   level_q;
    logic          push;
    logic          pop;

    assign full    = (level_q == DEPTH);
    assign empty   = (level_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (pop && !push) begin
                level_q <= level_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dev_uart_tx.sv
// Device-side UART transmitter: FIFO-fed 8N frames at an NCO baud with
// RTS/CTS gating. Define DEV_UART_TX_PARITY_EN to add the parity bit.
module dev_uart_tx
    import dev_uart_tx_pkg::*;
#(
    parameter int FIFO_AW = DUTX_FIFO_AW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      baud_nco,
    input  logic [3:0]       stop_bit,
    input  logic             flow_control,
    input  logic             cts,
`ifdef DEV_UART_TX_PARITY_EN
    input  logic             parity_en,
    input  logic             parity_odd,
`endif
    output logic             txd,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             fifo_full,
    output logic [FIFO_AW:0] fifo_level,
    output logic             overflow,
    output logic             tx_busy
);

    dutx_state_e state_q;
    logic        cts_m_q;
    logic        cts_s_q;
    logic [31:0] acc_q;
    logic [32:0] acc_d;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [3:0]  stop_cnt_q;
    logic        txd_q;
    logic        busy_q;
    logic        tick;
    logic        send_ok;
    logic        stop_done;
    logic        pop;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
`ifdef DEV_UART_TX_PARITY_EN
    logic        par_en_q;
    logic        par_bit_q;
`endif

    dev_uart_tx_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign acc_d     = {1'b0, acc_q} + {1'b0, baud_nco};
    assign tick      = acc_d[32];
    assign send_ok   = !flow_control || !cts_s_q;
    assign stop_done = (state_q == DUTX_STOP) && tick &&
                       (({1'b0, stop_cnt_q} + 5'd1) >= dutx_stop_lim(stop_bit));
    // Pop from IDLE, or straight out of the last stop period for back-to-back frames.
    assign pop       = !fifo_empty && send_ok &&
                       ((state_q == DUTX_IDLE) || stop_done);
    assign overflow  = wr_en && fifo_full;
    assign txd       = txd_q;
    assign tx_busy   = busy_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= DUTX_IDLE;
            cts_m_q    <= 1'b1;
            cts_s_q    <= 1'b1;
            acc_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            txd_q      <= DUTX_LINE_IDLE;
            busy_q     <= 1'b0;
`ifdef DEV_UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            cts_m_q <= cts;
            cts_s_q <= cts_m_q;
            acc_q   <= acc_d[31:0];
            if (pop) begin
                state_q <= DUTX_START;
                shift_q <= fifo_rd_data;
                acc_q   <= '0;
                txd_q   <= 1'b0;
                busy_q  <= 1'b1;
`ifdef DEV_UART_TX_PARITY_EN
                par_en_q  <= parity_en;
                par_bit_q <= parity_odd ? ~^fifo_rd_data : ^fifo_rd_data;
`endif
            end else begin
                unique case (state_q)
                    DUTX_IDLE: begin
                        acc_q <= '0;
                    end
                    DUTX_START: begin
                        if (tick) begin
                            state_q   <= DUTX_DATA;
                            bit_cnt_q <= '0;
                            txd_q     <= shift_q[0];
                        end
                    end
                    DUTX_DATA: begin
                        if (tick) begin
                            shift_q    <= {1'b0, shift_q[7:1]};
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            stop_cnt_q <= '0;
                            if (bit_cnt_q == 3'd7) begin
`ifdef DEV_UART_TX_PARITY_EN
                                state_q <= par_en_q ? DUTX_PARITY : DUTX_STOP;
                                txd_q   <= par_en_q ? par_bit_q : DUTX_LINE_IDLE;
`else
                                state_q <= DUTX_STOP;
                                txd_q   <= DUTX_LINE_IDLE;
`endif
                            end else begin
                                txd_q <= shift_q[1];
                            end
                        end
                    end
`ifdef DEV_UART_TX_PARITY_EN
                    DUTX_PARITY: begin
                        if (tick) begin
                            state_q <= DUTX_STOP;
                            txd_q   <= DUTX_LINE_IDLE;
                        end
                    end
`endif
                    DUTX_STOP: begin
                        if (stop_done) begin
                            state_q <= DUTX_IDLE;
                            busy_q  <= 1'b0;
                            txd_q   <= DUTX_LINE_IDLE;
                            acc_q   <= '0;
                        end else if (tick) begin
                            stop_cnt_q <= stop_cnt_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q <= DUTX_IDLE;
                        busy_q  <= 1'b0;
                        txd_q   <= DUTX_LINE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dev_uart_tx.sv
// Self-checking bench for dev_uart_tx: a line monitor decodes frames
// from txd and is compared against a queue of expected bytes.
`timescale 1ns/1ps
module tb_dev_uart_tx;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset_n;
    logic [31:0] baud_nco;
    logic [3:0]  stop_bit;
    logic        flow_control;
    logic        cts;
    logic        txd;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        fifo_full;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        tx_busy;
`ifdef DEV_UART_TX_PARITY_EN
    logic        parity_en;
    logic        parity_odd;
`endif

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    real    bit_p = 16.0;
    bit     mon_en = 0;
    bit     mon_par = 0;
    int     mon_starts = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    longint     rx_t[$];
    logic       rx_p[$];

    dev_uart_tx #(
        .FIFO_AW(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .baud_nco     (baud_nco),
        .stop_bit     (stop_bit),
        .flow_control (flow_control),
        .cts          (cts),
`ifdef DEV_UART_TX_PARITY_EN
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
`endif
        .txd          (txd),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .tx_busy      (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: finds a start bit, then samples each bit at mid-period.
    initial begin
        longint     c0;
        longint     tgt;
        logic [10:0] bits;
        int         nb;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n && txd === 1'b0) begin
                c0 = cyc;
                mon_starts++;
                nb = mon_par ? 11 : 10;
                bits = '1;
                for (int k = 0; k < nb; k++) begin
                    tgt = c0 + longint'($rtoi((k + 0.5) * bit_p));
                    while (cyc < tgt) @(negedge clk);
                    bits[k] = txd;
                end
                checks++;
                if (bits[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL mon_start: got %b want 0", bits[0]);
                end
                checks++;
                if (bits[nb-1] !== 1'b1) begin
                    errors++;
                    $display("FAIL mon_stop: got %b want 1", bits[nb-1]);
                end
                rx_q.push_back(bits[8:1]);
                rx_t.push_back(c0);
                rx_p.push_back(bits[9]);
            end
        end
    end

    task automatic set_nco(input logic [31:0] n);
        baud_nco = n;
        bit_p = 4294967296.0 / real'(n);
    endtask

    task automatic set_period(input int p);
        logic [63:0] q;
        q = 64'h1_0000_0000 / 64'(p);
        set_nco(q[31:0]);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clear_q();
        rx_q.delete();
        rx_t.delete();
        rx_p.delete();
        exp_q.delete();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((fifo_level != 0 || tx_busy) && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: level=%0d busy=%0b want idle", fifo_level, tx_busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        checks++;
        if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        checks++;
        if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_baseline();
        int     n;
        longint cb;
        real    dv;
        set_nco(32'd9895604);
        stop_bit = 4'd1;
        flow_control = 1'b0;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 5'd1) begin
            errors++;
            $display("FAIL lat_push: txd=%b busy=%b lvl=%0d want 1 0 1", txd, tx_busy, fifo_level);
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b0 || tx_busy !== 1'b1 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL lat_pop: txd=%b busy=%b lvl=%0d want 0 1 0", txd, tx_busy, fifo_level);
        end
        cb = cyc;
        n = 0;
        while (txd === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n < 433 || n > 435) begin errors++; $display("FAIL start_len: got %0d want 434+-1", n); end
        while (tx_busy === 1'b1 && cyc - cb < 6000) @(negedge clk);
        dv = real'(cyc - cb) - 10.0 * bit_p;
        checks++;
        if (dv > 2.0 || dv < -2.0) begin
            errors++;
            $display("FAIL busy_len: got %0d want %0d", cyc - cb, $rtoi(10.0 * bit_p));
        end
        drain(200);
        checks++;
        if (rx_q.size() != 1) begin
            errors++;
            $display("FAIL base_cnt: got %0d want 1", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL base_byte: got %h want a5", rx_q[0]); end
        end
        clear_q();
    endtask

    task automatic test_random();
        int  p;
        int  sb;
        real dv;
        for (int r = 0; r < 3; r++) begin
            p = $urandom_range(8, 40);
            sb = $urandom_range(0, 3);
            set_period(p);
            stop_bit = 4'(sb);
            for (int i = 0; i < 6; i++) begin
                exp_q.push_back(8'($urandom));
                push(exp_q[i]);
            end
            drain(20000);
            checks++;
            if (rx_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rnd_cnt: got %0d want %0d", rx_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (rx_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rnd_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
                    end
                    if (i > 0) begin
                        dv = real'(rx_t[i] - rx_t[i-1]) - real'(9 + ((sb == 0) ? 1 : sb)) * bit_p;
                        checks++;
                        if (dv > 2.0 || dv < -2.0) begin
                            errors++;
                            $display("FAIL rnd_gap[%0d]: got %0d off by %0f", i, rx_t[i] - rx_t[i-1], dv);
                        end
                    end
                end
            end
            clear_q();
        end
    endtask

    task automatic test_flow();
        int lo;
        int st0;
        int n;
        set_period(16);
        stop_bit = 4'd1;
        flow_control = 1'b1;
        cts = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            push(8'(i));
        end
        lo = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1) lo++;
        end
        checks++;
        if (lo != 0) begin errors++; $display("FAIL flow_hold: got %0d low cycles want 0", lo); end
        checks++;
        if (fifo_level !== 5'd3) begin errors++; $display("FAIL flow_level: got %0d want 3", fifo_level); end
        st0 = mon_starts;
        cts = 1'b0;
        n = 0;
        while (mon_starts < st0 + 2 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 2000) begin errors++; $display("FAIL flow_start2: got %0d starts want 2", mon_starts - st0); end
        repeat (48) @(negedge clk);
        cts = 1'b1;
        repeat (640) @(negedge clk);
        checks++;
        if (mon_starts != st0 + 2) begin errors++; $display("FAIL flow_held: got %0d starts want 2", mon_starts - st0); end
        checks++;
        if (fifo_level !== 5'd1 || tx_busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL flow_idle: lvl=%0d busy=%b txd=%b want 1 0 1", fifo_level, tx_busy, txd);
        end
        checks++;
        if (rx_q.size() != 2) begin
            errors++;
            $display("FAIL flow_cnt: got %0d want 2", rx_q.size());
        end else begin
            checks++;
            if (rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1]) begin
                errors++;
                $display("FAIL flow_bytes: got %h %h want %h %h", rx_q[0], rx_q[1], exp_q[0], exp_q[1]);
            end
            checks++;
            if (rx_t[1] - rx_t[0] != 160) begin
                errors++;
                $display("FAIL flow_b2b: got %0d want 160", rx_t[1] - rx_t[0]);
            end
        end
        cts = 1'b0;
        drain(2000);
        checks++;
        if (rx_q.size() != 3) begin
            errors++;
            $display("FAIL flow_cnt3: got %0d want 3", rx_q.size());
        end else begin
            checks++;
            if (rx_q[2] !== exp_q[2]) begin errors++; $display("FAIL flow_b3: got %h want %h", rx_q[2], exp_q[2]); end
        end
        clear_q();
    endtask

    task automatic test_fifo_full();
        int         cnt;
        int         ov;
        logic [7:0] b;
        set_period(16);
        flow_control = 1'b1;
        cts = 1'b1;
        repeat (4) @(negedge clk);
        cnt = 0;
        ov = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            b = 8'($urandom);
            wr_en = 1'b1;
            wr_data = b;
            #1;
            if (i == 15) begin
                checks++;
                if (fifo_full !== 1'b0) begin errors++; $display("FAIL full_early: got %b want 0", fifo_full); end
            end
            if (i == 16) begin
                checks++;
                if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_16: got %b want 1", fifo_full); end
                checks++;
                if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_17: got %b want 1", overflow); end
            end
            if (overflow === 1'b1) ov++;
            if (cnt < DEPTH) begin
                exp_q.push_back(b);
                cnt++;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        checks++;
        if (ov != 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", ov); end
        checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_level: lvl=%0d ovf=%b want 16 0", fifo_level, overflow);
        end
        cts = 1'b0;
        drain(5000);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL full_cnt: got %0d want %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL full_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        flow_control = 1'b0;
        clear_q();
    endtask

    task automatic test_stop_bits();
        real dv;
        set_period(16);
        stop_bit = 4'd0;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        push(8'h3C);
        push(8'hC3);
        drain(1000);
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3) begin
            errors++;
            $display("FAIL stop0_bytes: got %0d frames want 2 (3c c3)", rx_q.size());
        end else begin
            dv = real'(rx_t[1] - rx_t[0]) - 10.0 * bit_p;
            checks++;
            if (dv > 2.0 || dv < -2.0) begin
                errors++;
                $display("FAIL stop0_gap: got %0d want 160", rx_t[1] - rx_t[0]);
            end
        end
        clear_q();
        set_nco(32'd9895604);
        stop_bit = 4'd2;
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        push(8'h81);
        push(8'h7E);
        drain(12000);
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h81 || rx_q[1] !== 8'h7E) begin
            errors++;
            $display("FAIL stop2_bytes: got %0d frames want 2 (81 7e)", rx_q.size());
        end else begin
            dv = real'(rx_t[1] - rx_t[0]) - 9.0 * bit_p - 868.0;
            checks++;
            if (dv > 2.0 || dv < -2.0) begin
                errors++;
                $display("FAIL stop2_high: got %0f want 868+-2", real'(rx_t[1] - rx_t[0]) - 9.0 * bit_p);
            end
        end
        stop_bit = 4'd1;
        clear_q();
    endtask

    task automatic test_reset_mid();
        longint c0;
        int     n;
        mon_en = 1'b0;
        set_period(16);
        push(8'h77);
        push(8'h33);
        n = 0;
        while (txd !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL rst_start: got no start bit want one"); end
        c0 = cyc;
        while (cyc < c0 + 72) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid: txd=%b busy=%b lvl=%0d want 1 0 0", txd, tx_busy, fifo_level);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        clear_q();
        mon_en = 1'b1;
        exp_q.push_back(8'h5A);
        push(8'h5A);
        drain(1000);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
            errors++;
            $display("FAIL rst_after: got %0d frames want 1 (5a)", rx_q.size());
        end
        clear_q();
    endtask

`ifdef DEV_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        logic       exp_p;
        real        dv;
        set_period(16);
        mon_par = 1'b1;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        push(8'h07);
        drain(1000);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h07 || rx_p[0] !== 1'b1) begin
            errors++;
            $display("FAIL par_even: got %0d frames want 07 with parity 1", rx_q.size());
        end
        clear_q();
        parity_odd = 1'b1;
        push(8'h07);
        drain(1000);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h07 || rx_p[0] !== 1'b0) begin
            errors++;
            $display("FAIL par_odd: got %0d frames want 07 with parity 0", rx_q.size());
        end
        clear_q();
        parity_odd = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push(b);
        end
        drain(2000);
        checks++;
        if (rx_q.size() != 3) begin
            errors++;
            $display("FAIL par_cnt: got %0d want 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_p = parity_odd ? ~^exp_q[i] : ^exp_q[i];
                checks++;
                if (rx_q[i] !== exp_q[i] || rx_p[i] !== exp_p) begin
                    errors++;
                    $display("FAIL par_rnd[%0d]: got %h/%b want %h/%b", i, rx_q[i], rx_p[i], exp_q[i], exp_p);
                end
                if (i > 0) begin
                    dv = real'(rx_t[i] - rx_t[i-1]) - 11.0 * bit_p;
                    checks++;
                    if (dv > 2.0 || dv < -2.0) begin
                        errors++;
                        $display("FAIL par_len[%0d]: got %0d want 176", i, rx_t[i] - rx_t[i-1]);
                    end
                end
            end
        end
        clear_q();
        parity_en = 1'b0;
        mon_par = 1'b0;
        exp_q.push_back(8'hE4);
        exp_q.push_back(8'h1B);
        push(8'hE4);
        push(8'h1B);
        drain(1000);
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hE4 || rx_q[1] !== 8'h1B || rx_t[1] - rx_t[0] != 160) begin
            errors++;
            $display("FAIL par_off: got %0d frames want 2 (e4 1b) 160 apart", rx_q.size());
        end
        clear_q();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        baud_nco = 32'd0;
        stop_bit = 4'd1;
        flow_control = 1'b0;
        cts = 1'b1;
`ifdef DEV_UART_TX_PARITY_EN
        parity_en = 1'b0;
        parity_odd = 1'b0;
`endif
        test_reset();
        test_baseline();
        test_random();
        test_flow();
        test_fifo_full();
        test_stop_bits();
        test_reset_mid();
`ifdef DEV_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
